fir_decim_rate_ctrl: RTL

//  Rate-change sequencer for the N-channel decimating FIR (decim 2/4/8/16, 8 clocks per input sample).

---
 rtl/fir_decim_pkg.sv | 23 ++
 rtl/fir_decim_rate_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fir_decim_pkg.sv
// Shared definitions for the decimating FIR and its rate-change sequencer.
//   rate_e          : FIR 'sel' rate codes (/2, /4, /8, /16)
//   rc_state_e      : rate-change sequencer state encoding
//   FIR_CLK_PER_IN  : clocks per FIR input sample
package fir_decim_pkg;

   typedef enum logic [1:0] {
      RATE_D2  = 2'd0,
      RATE_D4  = 2'd1,
      RATE_D8  = 2'd2,
      RATE_D16 = 2'd3
   } rate_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_APPLY = 2'd2,
      ST_FLUSH = 2'd3
   } rc_state_e;

   localparam int FIR_CLK_PER_IN = 8;

endpackage

// File: rtl/fir_decim_rate_ctrl.sv
// Rate-change sequencer for the decimating FIR. Takes rate requests from the
// host register block, applies them right after a FIR output strobe so the FIR
// state counter stays phase-aligned, then blanks output strobes until the
// delay line holds only post-change samples.
// Ports:
//   c, rst        clock (8*FS in), synchronous active-high reset
//   req_sel/force/valid, req_ready   host rate request handshake
//   sel           rate code to the FIR
//   fir_ov / ov   raw FIR output strobe / gated strobe to the packer
//   busy          change in progress (WAIT, APPLY, FLUSH)
//   timeout_evt   one-cycle pulse when a change was forced by the timeout
//   settle_cnt    strobes discarded so far in the current flush
//
// state | meaning
// RUN   | normal operation, strobes pass, requests accepted
// WAIT  | change pending, waiting for a boundary strobe or timeout
// APPLY | one cycle, new rate code loaded into sel
// FLUSH | discarding SETTLE_OV strobes while the delay line refills
module fir_decim_rate_ctrl
   import fir_decim_pkg::*;
#(
   parameter logic [1:0] INIT_SEL  = 2'd0,
   parameter int         SETTLE_OV = 64,
   parameter int         TIMEOUT   = 1023
) (
   input  logic       c,
   input  logic       rst,
   input  logic [1:0] req_sel,
   input  logic       req_force,
   input  logic       req_valid,
   output logic       req_ready,
   output logic [1:0] sel,
   input  logic       fir_ov,
   output logic       ov,
   output logic       busy,
   output logic       timeout_evt,
   output logic [7:0] settle_cnt
);

   localparam int TMO_CLOG = $clog2(TIMEOUT + 1);
   localparam int TMO_W    = (TMO_CLOG > 10) ? TMO_CLOG : 10;
   // Timeout is a down-counter: loaded on WAIT entry, terminal count at zero
   // lands on the same cycle an up-count would reach TIMEOUT-1.
   localparam logic [TMO_W-1:0] TMO_LOAD    = TMO_W'(TIMEOUT - 1);
   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_OV - 1);

   rc_state_e        state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       pend_q, pend_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [7:0]       settle_q, settle_d;
   logic             tevt_q, tevt_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      pend_d   = pend_q;
      tmo_d    = tmo_q;
      settle_d = settle_q;
      tevt_d   = 1'b0;
      case (state_q)
         ST_RUN: begin
            // Same code without force is a no-op: stay in RUN, ov untouched.
            if (req_valid && ((req_sel != sel_q) || req_force)) begin
               pend_d  = req_sel;
               tmo_d   = TMO_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A strobe on the terminal cycle counts as a real boundary.
            if (fir_ov) begin
               state_d = ST_APPLY;
            end else if (tmo_q == '0) begin
               state_d = ST_APPLY;
               tevt_d  = 1'b1;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         ST_APPLY: begin
            sel_d    = pend_q;
            settle_d = 8'd0;
            state_d  = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (fir_ov) begin
               if (settle_q == SETTLE_LAST) begin
                  settle_d = 8'd0;
                  state_d  = ST_RUN;
               end else begin
                  settle_d = settle_q + 8'd1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
      ready_d = (state_d == ST_RUN);
      busy_d  = (state_d != ST_RUN);
   end

   always_ff @(posedge c) begin
      if (rst) begin
         state_q  <= ST_RUN;
         sel_q    <= INIT_SEL;
         pend_q   <= INIT_SEL;
         tmo_q    <= '0;
         settle_q <= 8'd0;
         tevt_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         pend_q   <= pend_d;
         tmo_q    <= tmo_d;
         settle_q <= settle_d;
         tevt_q   <= tevt_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   // Zero-latency pass of the raw strobe while running.
   assign ov          = fir_ov & ready_q;
   assign req_ready   = ready_q;
   assign busy        = busy_q;
   assign sel         = sel_q;
   assign timeout_evt = tevt_q;
   assign settle_cnt  = settle_q;

endmodule
